// File: rtl/hvsync_generator_vga.sv
// hvsync_generator_vga: free-running 640x480 (800x525 total) VGA raster timing generator.
// Define HVSYNC_NEG_POLARITY_EN for active-low hsync/vsync.
module hvsync_generator_vga #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
`ifdef HVSYNC_NEG_POLARITY_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif
    logic       h_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;
    // >= rather than == so any stray out-of-range count recovers at the next wrap
    always_comb begin
        h_wrap = hpos >= H_MAX;
        h_next = h_wrap ? '0 : hpos + 10'd1;
        v_next = !h_wrap ? vpos : (vpos >= V_MAX ? '0 : vpos + 10'd1);
    end
    // syncs are decoded from the next position so they line up with hpos/vpos
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos  <= '0;
            vpos  <= '0;
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
        end else begin
            hpos  <= h_next;
            vpos  <= v_next;
            hsync <= (h_next >= H_SYNC_START && h_next <= H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
            vsync <= (v_next >= V_SYNC_START && v_next <= V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
        end
    end
    assign display_on = (hpos < H_DISP) && (vpos < V_DISP);
endmodule

// File: tb/tb_hvsync_generator_vga.sv
// tb_hvsync_generator_vga: checks a full-size and a shrunken-timing instance against a
// cycle-count model (position = clocks since reset release, modulo line/frame length).
module tb_hvsync_generator_vga;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d_hs, d_vs, d_de, s_hs, s_vs, s_de;
    logic [9:0] d_h, d_v, s_h, s_v;
    int         errors = 0;
    int         checks = 0;
    int         t = 0;

`ifdef HVSYNC_NEG_POLARITY_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    always #5 clk = ~clk;

    hvsync_generator_vga dut_full (
        .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .hpos(d_h), .vpos(d_v)
    );

    // small timing so whole frames (vsync, frame wrap) fit in a short run
    hvsync_generator_vga #(
        .H_DISPLAY(64), .H_FRONT(6), .H_SYNC(10), .H_BACK(8),
        .V_DISPLAY(40), .V_BOTTOM(3), .V_SYNC(2), .V_TOP(4)
    ) dut_small (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .hpos(s_h), .vpos(s_v)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_inst(input string n, input int c,
                              input int hd, input int hf, input int hsw, input int hb,
                              input int vd, input int vb, input int vsw, input int vt,
                              input logic hs, input logic vs, input logic de,
                              input logic [9:0] h, input logic [9:0] v);
        int ht, vtot, eh, ev;
        ht   = hd + hf + hsw + hb;
        vtot = vd + vb + vsw + vt;
        eh   = c % ht;
        ev   = (c / ht) % vtot;
        check($sformatf("%s.hpos@%0d", n, c), 32'(h), 32'(eh));
        check($sformatf("%s.vpos@%0d", n, c), 32'(v), 32'(ev));
        check($sformatf("%s.hsync@%0d", n, c), 32'(hs), 32'(((eh >= hd + hf && eh < hd + hf + hsw) ? 1'b1 : 1'b0) ^ POL));
        check($sformatf("%s.vsync@%0d", n, c), 32'(vs), 32'(((ev >= vd + vb && ev < vd + vb + vsw) ? 1'b1 : 1'b0) ^ POL));
        check($sformatf("%s.display_on@%0d", n, c), 32'(de), 32'((eh < hd && ev < vd) ? 1 : 0));
    endtask

    task automatic check_all(input int c);
        check_inst("full", c, 640, 16, 96, 48, 480, 10, 2, 33, d_hs, d_vs, d_de, d_h, d_v);
        check_inst("small", c, 64, 6, 10, 8, 40, 3, 2, 4, s_hs, s_vs, s_de, s_h, s_v);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            check_all(t);
        end
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_all(0);
        reset = 1'b1;
        t = 0;
        run(2500);
        for (int k = 0; k < 3; k++) begin
            run(4312 + $urandom_range(0, 3000));
            @(posedge clk);
            t++;
            #($urandom_range(1, 3));
            reset = 1'b0;
            #1;
            check_all(0);
            repeat ($urandom_range(1, 6)) begin
                @(negedge clk);
                check_all(0);
            end
            reset = 1'b1;
            t = 0;
        end
        run(2 * 4312 + 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
